// File: rtl/bus_terminal_fifo.sv
// Bus terminal endpoint: host-loaded TX FIFO facing the bus pop side, and an
// ID-filtered RX FIFO fed by bus pushes, with misroute/overflow reporting.
module bus_terminal_fifo_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          rd_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rd_ok = rd && !empty;
  // a write into a full buffer still fits when the head leaves in the same edge
  assign wr_ok = wr && (!full || rd_ok);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module bus_terminal_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] term_id   = 8'h00,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic [15:0]                misroute_cnt,
  output logic                       err_pop_empty,
  output logic                       err_rx_ovf
);
  localparam int CW = $clog2(depth+1);

  logic       tx_empty, tx_rd_ok, rx_full, rx_rd_ok, rx_wr, match;
  logic [7:0] dest;

  bus_terminal_fifo_buf #(.W(pckg_sz), .DEPTH(depth), .CW(CW)) u_tx (
    .clk(clk), .reset(reset), .wr(wr_en), .wr_data(wr_data), .rd(pop),
    .head(D_pop), .count(tx_count), .full(tx_full), .empty(tx_empty),
    .rd_ok(tx_rd_ok)
  );

  assign pndng = !tx_empty;
  assign dest  = D_push[pckg_sz-1 -: 8];
  assign match = (dest == term_id) || (dest == broadcast);
  assign rx_wr = push && match;

  bus_terminal_fifo_buf #(.W(pckg_sz), .DEPTH(depth), .CW(CW)) u_rx (
    .clk(clk), .reset(reset), .wr(rx_wr), .wr_data(D_push), .rd(rd_en),
    .head(rd_data), .count(rx_count), .full(rx_full), .empty(rx_empty),
    .rd_ok(rx_rd_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_cnt  <= '0;
      err_pop_empty <= 1'b0;
      err_rx_ovf    <= 1'b0;
    end else begin
      if (push && !match && misroute_cnt != 16'hFFFF)
        misroute_cnt <= misroute_cnt + 16'd1;
      if (pop && !tx_rd_ok)
        err_pop_empty <= 1'b1;
      if (rx_wr && rx_full && !rx_rd_ok)
        err_rx_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed bench for bus_terminal_fifo (depth 8, term_id 8'h03).
module tb_bus_terminal_fifo;
  logic        clk = 1'b0, reset = 1'b1;
  logic        wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0, D_push = '0;
  logic        tx_full, pndng, rx_empty, err_pop_empty, err_rx_ovf;
  logic [3:0]  tx_count, rx_count;
  logic [15:0] D_pop, rd_data, misroute_cnt;
  int checks = 0, failures = 0;

  bus_terminal_fifo #(.pckg_sz(16), .depth(8), .term_id(8'h03)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .rd_en(rd_en),
    .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .misroute_cnt(misroute_cnt), .err_pop_empty(err_pop_empty),
    .err_rx_ovf(err_rx_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_pndng", pndng, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_dpop", D_pop, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_misroute", misroute_cnt, 0);
    chk("rst_flags", {err_pop_empty, err_rx_ovf}, 0);
    tick();
    reset = 1'b0;
    tick();

    // basic TX ordering
    wr_en = 1; wr_data = 16'h00A1; tick();
    chk("tx_pndng_first", pndng, 1);
    chk("tx_head_first", D_pop, 16'h00A1);
    wr_data = 16'h00B2; tick();
    wr_data = 16'h00C3; tick();
    wr_en = 0;
    chk("tx_count3", tx_count, 3);
    pop = 1; tick();
    chk("tx_head_b2", D_pop, 16'h00B2);
    tick();
    chk("tx_head_c3", D_pop, 16'h00C3);
    tick();
    pop = 0;
    chk("tx_drained_pndng", pndng, 0);
    chk("tx_drained_count", tx_count, 0);
    chk("tx_drained_dpop", D_pop, 0);

    // TX full, dropped write, write+pop at full, wrap ordering
    wr_en = 1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 16'h1000 + 16'(i); tick();
    end
    chk("tx_full", tx_full, 1);
    wr_data = 16'h10FF; tick();
    chk("tx_drop_count", tx_count, 8);
    chk("tx_drop_head", D_pop, 16'h1000);
    wr_data = 16'h1008; pop = 1; tick();
    wr_en = 0;
    chk("tx_wrpop_count", tx_count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("tx_wrap_order", D_pop, 16'h1000 + 16'(i));
      tick();
    end
    pop = 0;
    chk("tx_wrap_empty", pndng, 0);
    chk("tx_no_err_yet", err_pop_empty, 0);

    // pop while empty
    pop = 1; tick(); pop = 0;
    chk("pop_empty_flag", err_pop_empty, 1);
    chk("pop_empty_count", tx_count, 0);
    tick(); tick();
    chk("pop_empty_sticky", err_pop_empty, 1);

    // RX filtering
    push = 1; D_push = 16'h0311; tick();
    chk("rx_fwft", rd_data, 16'h0311);
    D_push = 16'hFF22; tick();
    D_push = 16'h0533; tick();
    push = 0;
    chk("rx_count2", rx_count, 2);
    chk("rx_misroute1", misroute_cnt, 1);
    rd_en = 1; tick();
    chk("rx_head_bcast", rd_data, 16'hFF22);
    tick();
    chk("rx_empty_after", rx_empty, 1);
    tick();
    rd_en = 0;
    chk("rx_rd_empty_ignored", rx_count, 0);

    // RX overflow
    push = 1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0300 + 16'(i); tick();
    end
    chk("rx_full_count", rx_count, 8);
    chk("rx_no_ovf_yet", err_rx_ovf, 0);
    D_push = 16'h03AA; tick();
    chk("rx_ovf_flag", err_rx_ovf, 1);
    chk("rx_ovf_count", rx_count, 8);
    chk("rx_ovf_head", rd_data, 16'h0300);
    D_push = 16'h03BB; rd_en = 1; tick();
    push = 0;
    chk("rx_rdpush_count", rx_count, 8);
    chk("rx_rdpush_flag", err_rx_ovf, 1);
    for (int i = 1; i < 8; i++) begin
      chk("rx_drain_order", rd_data, 16'h0300 + 16'(i));
      tick();
    end
    chk("rx_drain_last", rd_data, 16'h03BB);
    tick();
    rd_en = 0;
    chk("rx_drained", rx_empty, 1);
    chk("rx_misroute_hold", misroute_cnt, 1);

    // asynchronous reset mid-cycle
    wr_en = 1; push = 1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'h2000 + 16'(i);
      D_push  = (i < 3) ? 16'h0340 + 16'(i) : 16'h0700;
      tick();
    end
    wr_en = 0; push = 0;
    chk("pre_rst_tx", tx_count, 5);
    chk("pre_rst_rx", rx_count, 3);
    #2 reset = 1;
    #1;
    chk("arst_pndng", pndng, 0);
    chk("arst_rx_empty", rx_empty, 1);
    chk("arst_counts", {tx_count, rx_count}, 0);
    chk("arst_misroute", misroute_cnt, 0);
    chk("arst_flags", {err_pop_empty, err_rx_ovf}, 0);
    chk("arst_data", {D_pop, rd_data}, 0);
    tick();
    reset = 0;
    tick();
    chk("post_rst_pndng", pndng, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
